// File: rtl/timer_int_unit.sv
// Interrupt sources ahead of the CSR file: countdown timer, stable
// counter, SWI bits, synchronised HWI/IPI lines and a registered request.
module timer_int_unit #(
  parameter int HWI_NUM     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [HWI_NUM-1:0] hwi,
  input  logic               ipi,
  input  logic               tcfg_we,
  input  logic [31:0]        tcfg_wdata,
  input  logic               ticlr_we,
  input  logic [31:0]        ticlr_wdata,
  input  logic               swi_we,
  input  logic [1:0]         swi_wdata,
  input  logic [12:0]        ecfg_lie,
  input  logic               crmd_ie,
  output logic [31:0]        tcfg_out,
  output logic [31:0]        tval_out,
  output logic [12:0]        is_out,
  output logic               has_int,
  output logic [63:0]        timer_64
);

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2
  } tstate_e;

  tstate_e r_state;
  tstate_e w_state_nxt;

  logic [31:0] r_tcfg;
  logic [31:0] r_tval;
  logic        r_ti;
  logic [1:0]  r_swi;
  logic        r_has;
  logic [63:0] r_t64;

  logic [SYNC_STAGES-1:0][HWI_NUM-1:0] r_hwi_s;
  logic [SYNC_STAGES-1:0]              r_ipi_s;

  logic [31:0] w_tcfg_nxt;
  logic [31:0] w_tval_nxt;
  logic        w_ti_set;
  logic        w_ti_clr;
  logic        w_ti_nxt;
  logic [12:0] w_is;
  logic        w_unused_ticlr;

  assign w_unused_ticlr = ^ticlr_wdata[31:1];

  assign w_is = {r_ipi_s[SYNC_STAGES-1], r_ti, 1'b0,
                 r_hwi_s[SYNC_STAGES-1], r_swi};

  always_comb begin
    w_state_nxt = r_state;
    w_tcfg_nxt  = r_tcfg;
    w_tval_nxt  = r_tval;
    w_ti_set    = 1'b0;
    if (tcfg_we) begin
      w_tcfg_nxt  = tcfg_wdata;
      w_tval_nxt  = {tcfg_wdata[31:2], 2'b00};
      w_state_nxt = tcfg_wdata[0] ? T_RUN : T_IDLE;
    end else begin
      unique case (r_state)
        T_RUN: begin
          if (r_tval != 32'd0) begin
            w_tval_nxt = r_tval - 32'd1;
          end else begin
            w_ti_set = 1'b1;
            if (r_tcfg[1]) begin
              w_tval_nxt = {r_tcfg[31:2], 2'b00};
            end else begin
              w_tval_nxt  = 32'hFFFF_FFFF;
              w_state_nxt = T_DONE;
            end
          end
        end
        T_IDLE, T_DONE: ;
        default: w_state_nxt = T_IDLE;
      endcase
    end
  end

  // an expiry set beats a same-cycle TICLR clear
  assign w_ti_clr = ticlr_we & ticlr_wdata[0];
  assign w_ti_nxt = w_ti_set | (r_ti & ~w_ti_clr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= T_IDLE;
      r_tcfg  <= '0;
      r_tval  <= '0;
      r_ti    <= 1'b0;
      r_swi   <= '0;
      r_has   <= 1'b0;
      r_t64   <= '0;
      r_hwi_s <= '0;
      r_ipi_s <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tcfg  <= w_tcfg_nxt;
      r_tval  <= w_tval_nxt;
      r_ti    <= w_ti_nxt;
      if (swi_we) r_swi <= swi_wdata;
      r_has   <= (|(w_is & ecfg_lie)) & crmd_ie;
      r_t64   <= r_t64 + 64'd1;
      r_hwi_s <= {r_hwi_s[SYNC_STAGES-2:0], hwi};
      r_ipi_s <= {r_ipi_s[SYNC_STAGES-2:0], ipi};
    end
  end

  assign tcfg_out = r_tcfg;
  assign tval_out = r_tval;
  assign is_out   = w_is;
  assign has_int  = r_has;
  assign timer_64 = r_t64;

endmodule
